lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit controller: the initiator side of the data-memory port.
- Accepts one core load/store request at a time and decodes RISC-V funct3 width/sign.
- Drives the word-addressed, word-write data memory: word address bits [14:2], one-cycle registered read when write-enable is low.
- Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores; returns a one-cycle response pulse.

Parameters:
MEM_BYTES, 32768, data memory size in bytes; power of two; addresses >= MEM_BYTES are out of range.

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_req_valid  input  1  core request valid
o_req_ready  output  1  high only in IDLE; transfer occurs on valid&ready
i_req_we  input  1  1=store, 0=load
i_req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
i_req_addr  input  32  byte address
i_req_wdata  input  32  store data, LSB-aligned
o_rsp_valid  output  1  one-cycle response pulse
o_rsp_err  output  1  misaligned, illegal funct3, or out-of-range; valid with o_rsp_valid
o_rsp_rdata  output  32  formatted load data; 0 for stores and errors
o_lsu_addr  output  32  to memory; {addr[31:2],2'b00}, 0 in IDLE
o_st_data  output  32  to memory; full word to write
o_lsu_wren  output  1  to memory write enable
i_ld_data  input  32  from memory; valid the cycle after the address is presented with wren=0

Behaviour:
- Reset (async, low): state=IDLE; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_lsu_addr=0, o_st_data=0, o_lsu_wren=0. Outputs drop immediately on assertion.
- Request registers (addr, funct3, we, wdata) capture on accept.
- States:
  - IDLE: o_req_ready=1.
  - RD_ISSUE: drives addr, wren=0.
  - RD_CAPTURE: samples i_ld_data.
  - WR_ISSUE: drives addr, o_st_data and wren=1 for exactly one cycle.
- Transitions on accept at edge E0:
  - Error: stays IDLE; o_rsp_valid=1, err=1, rdata=0 in cycle E0+1; no memory access.
  - Load: IDLE->RD_ISSUE->RD_CAPTURE->IDLE; response visible cycle E0+3.
  - SW: IDLE->WR_ISSUE->IDLE; write at E1; response visible cycle E0+2.
  - SB/SH: IDLE->RD_ISSUE->RD_CAPTURE->WR_ISSUE->IDLE; merged word registered at E2, written at E3; response visible cycle E0+4.
- Error conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - Store with funct3 100/101.
  - addr >= MEM_BYTES.
- Load format:
  - B: byte lane addr[1:0], sign-extended.
  - BU: same lane, zero-extended.
  - H: half lane addr[1], sign-extended.
  - HU: same lane, zero-extended.
  - W: whole word.
- Store merge: SB replaces lane addr[1:0] with wdata[7:0]; SH replaces half addr[1] with wdata[15:0]; all other bits come from the read word.
- o_rsp_valid: registered, high exactly one cycle, no backpressure. o_rsp_err/rdata hold until the next response.
- o_req_ready is low in every non-IDLE state; valid held while busy is not accepted.
- A request in the same cycle as a response is allowed when the FSM is in IDLE: back-to-back loads at a 3-cycle issue rate.
- Reset mid-operation: the transaction is abandoned, no response is issued, and any pending RMW write is never issued.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and state enum lsu_state_t {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE}.
- Sub-module lsu_align: purely combinational load extract/extend and store merge (inputs: word, addr[1:0], funct3, wdata).

Test Plan:
- SW 0x100 data 0xDEADBEEF accepted at E0 -> wren=1 only in cycle 1, o_lsu_addr=0x100, o_st_data=0xDEADBEEF; rsp cycle 2, err=0.
- Memory word 0xDEADBEEF at 0x100, loads:
  - LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE.
  - LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF.
  - Each responds in cycle 3 with wren never high.
- SB 0x101 data 0x55 over 0xDEADBEEF -> read in cycle 1, wren cycle 3 with st_data 0xDEAD55EF, rsp cycle 4; following LW 0x100 -> 0xDEAD55EF.
- LW 0x102, SH 0x101, LW 0x8000, funct3 011 -> each gives rsp next cycle, err=1, rdata=0; wren stays 0; ready stays 1.
- Valid held during an SH RMW -> ready=0 throughout; second request accepted only on return to IDLE; exactly two responses.
- Reset asserted in RD_CAPTURE of SB 0x100 -> wren never asserted, rsp_valid stays 0; after release ready=1 and LW 0x100 returns the original word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, request legality.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE} lsu_state_t;

  // Width/alignment/direction legality only; the range check needs MEM_BYTES and lives in the top.
  function automatic logic req_fault(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic f;
    f = 1'b1;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = lo[0];
      F3_W:    f = (lo != 2'b00);
      F3_BU:   f = we;
      F3_HU:   f = we | lo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extract with sign/zero extension, and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word_i[{addr_lo_i, 3'b000} +: 8];
    lane_h = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    ld_data_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   ld_data_o = {24'h0, lane_b};
      F3_H:    ld_data_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   ld_data_o = {16'h0, lane_h};
      default: ld_data_o = word_i;
    endcase

    st_data_o = word_i;
    if (funct3_i == F3_B) begin
      st_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (funct3_i == F3_H) begin
      st_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, loads 3 cycles, SW 2, SB/SH read-modify-write 4.
// Ready only in IDLE; the response is a single-cycle pulse with no backpressure.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32768
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  input  logic [31:0] i_ld_data
);

  lsu_state_t  state_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        rsp_valid_q, rsp_err_q, wren_q;
  logic [31:0] rsp_rdata_q, lsu_addr_q, st_data_q;

  logic        req_fire;
  logic        req_err_d;
  logic [31:0] ld_fmt, st_merged;

  assign o_req_ready = (state_q == IDLE);
  assign req_fire    = i_req_valid && o_req_ready;
  assign req_err_d   = req_fault(i_req_we, i_req_funct3, i_req_addr[1:0]) ||
                       (i_req_addr >= MEM_BYTES);

  lsu_align u_align (
    .word_i    (i_ld_data),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_fmt),
    .st_data_o (st_merged)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      lsu_addr_q  <= '0;
      st_data_q   <= '0;
      wren_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      wren_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            addr_lo_q <= i_req_addr[1:0];
            funct3_q  <= i_req_funct3;
            we_q      <= i_req_we;
            wdata_q   <= i_req_wdata[15:0];
            if (req_err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (i_req_we && i_req_funct3 == F3_W) begin
              state_q    <= WR_ISSUE;
              lsu_addr_q <= {i_req_addr[31:2], 2'b00};
              st_data_q  <= i_req_wdata;
              wren_q     <= 1'b1;
            end else begin
              // Loads and sub-word stores both start with a read of the word.
              state_q    <= RD_ISSUE;
              lsu_addr_q <= {i_req_addr[31:2], 2'b00};
            end
          end
        end
        RD_ISSUE: state_q <= RD_CAPTURE;
        RD_CAPTURE: begin
          if (we_q) begin
            state_q   <= WR_ISSUE;
            st_data_q <= st_merged;
            wren_q    <= 1'b1;
          end else begin
            state_q     <= IDLE;
            lsu_addr_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= ld_fmt;
          end
        end
        WR_ISSUE: begin
          state_q     <= IDLE;
          lsu_addr_q  <= '0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_lsu_addr  = lsu_addr_q;
  assign o_st_data   = st_data_q;
  assign o_lsu_wren  = wren_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a word-wide registered-read memory attached.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_req_funct3 = 3'b000;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic [31:0] i_ld_data = '0;

  int passed = 0;
  int total  = 0;
  int rsp_cnt;

  logic [31:0] mem [0:8191];

  lsu_ctrl #(.MEM_BYTES(32768)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_err    (o_rsp_err),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_lsu_addr   (o_lsu_addr),
    .o_st_data    (o_st_data),
    .o_lsu_wren   (o_lsu_wren),
    .i_ld_data    (i_ld_data)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_lsu_wren) mem[o_lsu_addr[14:2]] <= o_st_data;
    else            i_ld_data <= mem[o_lsu_addr[14:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  // Issues one request and checks every cycle up to and including the response cycle.
  task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input int wr_cyc, input logic [31:0] exp_st,
                        input logic exp_err, input logic [31:0] exp_rd);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    chk({name, " ready_pre"}, 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin @(posedge i_clk); #1; end
      chk($sformatf("%s wren c%0d", name, k), 32'(o_lsu_wren), 32'(k == wr_cyc));
      chk($sformatf("%s rsp_valid c%0d", name, k), 32'(o_rsp_valid), 32'(k == lat));
      if (k == 1) chk({name, " lsu_addr"}, o_lsu_addr, exp_err ? 32'h0 : {addr[31:2], 2'b00});
      if (k == wr_cyc) chk({name, " st_data"}, o_st_data, exp_st);
      if (k == lat) begin
        chk({name, " err"}, 32'(o_rsp_err), 32'(exp_err));
        chk({name, " rdata"}, o_rsp_rdata, exp_rd);
        chk({name, " ready_rsp"}, 32'(o_req_ready), 32'd1);
      end else begin
        chk($sformatf("%s ready c%0d", name, k), 32'(o_req_ready), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;

    #12;
    chk("rst rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst rsp_rdata", o_rsp_rdata, 32'h0);
    chk("rst lsu_addr", o_lsu_addr, 32'h0);
    chk("rst st_data", o_st_data, 32'h0);
    chk("rst wren", 32'(o_lsu_wren), 32'd0);
    chk("rst ready", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;

    do_req("SW",  1'b1, F3_W,  32'h100, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 1'b0, 32'h0);
    do_req("LB",  1'b0, F3_B,  32'h103, 32'h0, 3, 0, 32'h0, 1'b0, 32'hFFFFFFDE);
    do_req("LBU", 1'b0, F3_BU, 32'h103, 32'h0, 3, 0, 32'h0, 1'b0, 32'h000000DE);
    do_req("LH",  1'b0, F3_H,  32'h102, 32'h0, 3, 0, 32'h0, 1'b0, 32'hFFFFDEAD);
    do_req("LHU", 1'b0, F3_HU, 32'h100, 32'h0, 3, 0, 32'h0, 1'b0, 32'h0000BEEF);
    do_req("SB",  1'b1, F3_B,  32'h101, 32'h55, 4, 3, 32'hDEAD55EF, 1'b0, 32'h0);
    do_req("LW",  1'b0, F3_W,  32'h100, 32'h0, 3, 0, 32'h0, 1'b0, 32'hDEAD55EF);

    do_req("LW mis",  1'b0, F3_W,   32'h102,  32'h0, 1, 0, 32'h0, 1'b1, 32'h0);
    do_req("SH mis",  1'b1, F3_H,   32'h101,  32'h0, 1, 0, 32'h0, 1'b1, 32'h0);
    do_req("LW oor",  1'b0, F3_W,   32'h8000, 32'h0, 1, 0, 32'h0, 1'b1, 32'h0);
    do_req("F3 011",  1'b0, 3'b011, 32'h100,  32'h0, 1, 0, 32'h0, 1'b1, 32'h0);
    do_req("SBU ill", 1'b1, F3_BU,  32'h100,  32'h0, 1, 0, 32'h0, 1'b1, 32'h0);

    // SH RMW with valid held high; the payload switches to a load right after acceptance.
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = F3_H;
    i_req_addr   = 32'h102;
    i_req_wdata  = 32'h1234;
    @(posedge i_clk); #1;
    i_req_we     = 1'b0;
    i_req_funct3 = F3_W;
    i_req_addr   = 32'h100;
    rsp_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) begin @(posedge i_clk); #1; end
      if (k == 5) i_req_valid = 1'b0;
      if (o_rsp_valid) rsp_cnt++;
      chk($sformatf("hold ready c%0d", k), 32'(o_req_ready), 32'(k == 4 || k >= 7));
      chk($sformatf("hold wren c%0d", k), 32'(o_lsu_wren), 32'(k == 3));
      chk($sformatf("hold rsp c%0d", k), 32'(o_rsp_valid), 32'(k == 4 || k == 7));
      if (k == 3) chk("hold st_data", o_st_data, 32'h123455EF);
      if (k == 7) chk("hold LW rdata", o_rsp_rdata, 32'h123455EF);
    end
    chk("hold rsp count", 32'(rsp_cnt), 32'd2);

    // Reset during RD_CAPTURE of an SB must drop the pending write.
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = F3_B;
    i_req_addr   = 32'h100;
    i_req_wdata  = 32'hAA;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("mid lsu_addr pre", o_lsu_addr, 32'h100);
    chk("mid ready pre", 32'(o_req_ready), 32'd0);
    i_reset = 1'b0;
    #1;
    chk("mid lsu_addr", o_lsu_addr, 32'h0);
    chk("mid ready", 32'(o_req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk); #1;
      if (k == 1) i_reset = 1'b1;
      chk($sformatf("mid wren c%0d", k), 32'(o_lsu_wren), 32'd0);
      chk($sformatf("mid rsp c%0d", k), 32'(o_rsp_valid), 32'd0);
      chk($sformatf("mid ready c%0d", k), 32'(o_req_ready), 32'd1);
    end
    do_req("LW post", 1'b0, F3_W, 32'h100, 32'h0, 3, 0, 32'h0, 1'b0, 32'h123455EF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
